alu_ctrl_mdu_seq: RTL

- Next-generation ALU control for the MIPS datapath.
- Decodes ALUop plus the R-type function field into a registered 4-bit ALU select. The opcode set is extended beyond the basic five ops.
- Adds a multi-cycle sequencer for mult/multu/div/divu. While that sequencer runs, it stalls the front end and pulses the HI/LO write enable on completion.
- Sits between the main control unit and the ALU/MDU in the EX stage.

---
 rtl/alu_ctrl_mdu_seq.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/alu_ctrl_mdu_seq.sv
// EX-stage ALU control decode plus mult/div sequencer with front-end stall.
// Optional: define ALU_SHIFT_EN to decode SLL/SRL/SRA.
module alu_ctrl_mdu_seq #(
  parameter int SEL_W      = 4,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [1:0]       ALUop,
  input  logic [5:0]       function_bit,
  output logic [SEL_W-1:0] select,
  output logic             sel_valid,
  output logic             illegal,
  output logic             stall,
  output logic             mdu_start,
  output logic [1:0]       mdu_op,
  output logic             hilo_we
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [SEL_W-1:0] SEL_AND  = SEL_W'(4'b0000);
  localparam logic [SEL_W-1:0] SEL_OR   = SEL_W'(4'b0001);
  localparam logic [SEL_W-1:0] SEL_ADD  = SEL_W'(4'b0010);
  localparam logic [SEL_W-1:0] SEL_XOR  = SEL_W'(4'b0011);
  localparam logic [SEL_W-1:0] SEL_SUB  = SEL_W'(4'b0110);
  localparam logic [SEL_W-1:0] SEL_SLT  = SEL_W'(4'b0111);
  localparam logic [SEL_W-1:0] SEL_SLTU = SEL_W'(4'b1000);
`ifdef ALU_SHIFT_EN
  localparam logic [SEL_W-1:0] SEL_SLL  = SEL_W'(4'b1001);
  localparam logic [SEL_W-1:0] SEL_SRL  = SEL_W'(4'b1010);
  localparam logic [SEL_W-1:0] SEL_SRA  = SEL_W'(4'b1011);
`endif
  localparam logic [SEL_W-1:0] SEL_NOR  = SEL_W'(4'b1100);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             start_q;
  logic [1:0]       op_q;

  logic [SEL_W-1:0] dec_sel;
  logic             dec_ill;
  logic             dec_mdu;
  logic [1:0]       dec_op;
  logic             accept;
  logic             start_now;
  logic             restart;
  logic [CNT_W-1:0] ld_full;
  logic [CNT_W-1:0] ld_short;

  always_comb begin
    dec_sel = SEL_ADD;
    dec_ill = 1'b0;
    dec_mdu = 1'b0;
    unique case (ALUop)
      2'b00: dec_sel = SEL_ADD;
      2'b01: dec_sel = SEL_SUB;
      2'b11: dec_ill = 1'b1;
      default: begin
        unique case (function_bit)
          6'b100000, 6'b100001: dec_sel = SEL_ADD;
          6'b100010, 6'b100011: dec_sel = SEL_SUB;
          6'b100100: dec_sel = SEL_AND;
          6'b100101: dec_sel = SEL_OR;
          6'b100110: dec_sel = SEL_XOR;
          6'b100111: dec_sel = SEL_NOR;
          6'b101010: dec_sel = SEL_SLT;
          6'b101011: dec_sel = SEL_SLTU;
`ifdef ALU_SHIFT_EN
          6'b000000: dec_sel = SEL_SLL;
          6'b000010: dec_sel = SEL_SRL;
          6'b000011: dec_sel = SEL_SRA;
`endif
          6'b010000, 6'b010010: dec_sel = SEL_ADD;
          6'b011000, 6'b011001,
          6'b011010, 6'b011011: dec_mdu = 1'b1;
          default: dec_ill = 1'b1;
        endcase
      end
    endcase
  end

  assign dec_op    = function_bit[1:0];
  assign stall     = (state == S_BUSY);
  assign accept    = valid_in && !stall;
  assign start_now = accept && dec_mdu;
  assign restart   = (state == S_DONE) && start_now;

  // A restart from DONE already spends its start cycle in DONE.
  assign ld_full  = dec_op[1] ? CNT_W'(DIV_CYCLES - 1)
                              : CNT_W'(MUL_CYCLES - 1);
  assign ld_short = dec_op[1] ? CNT_W'(DIV_CYCLES - 2)
                              : CNT_W'(MUL_CYCLES - 2);

  assign mdu_start = !reset && (start_q || restart);
  assign mdu_op    = restart ? dec_op : op_q;
  assign hilo_we   = !reset && (state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      start_q   <= 1'b0;
      op_q      <= 2'b00;
      select    <= '0;
      sel_valid <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      sel_valid <= accept;
      start_q   <= 1'b0;
      if (accept) begin
        select  <= dec_sel;
        illegal <= dec_ill;
      end
      unique case (state)
        S_IDLE: begin
          if (start_now) begin
            state   <= S_BUSY;
            cnt     <= ld_full;
            op_q    <= dec_op;
            start_q <= 1'b1;
          end
        end
        S_BUSY: begin
          if (cnt == '0) state <= S_DONE;
          else cnt <= cnt - CNT_W'(1);
        end
        S_DONE: begin
          if (start_now) begin
            state <= S_BUSY;
            cnt   <= ld_short;
            op_q  <= dec_op;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
